// File: rtl/hash_tx.sv
// hash_tx: serialises a captured SHA3-512 digest into a UART character stream,
// either as raw bytes or lowercase ASCII hex, optionally terminated by CR/LF.
module hash_tx #(
    parameter int unsigned HEX_MODE    = 1,
    parameter int unsigned APPEND_CRLF = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [511:0] hash_i,
    input  logic         hash_valid_i,
    output logic [7:0]   tx_data_o,
    output logic         tx_valid_o,
    input  logic         tx_ready_i,
    output logic         busy_o,
    output logic         done_o
);

    localparam int unsigned N_CHARS  = 32'd64 * (32'd1 + HEX_MODE) + 32'd2 * APPEND_CRLF;
    localparam logic [7:0]  LAST_IDX = 8'(N_CHARS - 32'd1);
    localparam logic [7:0]  CR_IDX   = 8'(N_CHARS - 32'd2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_nx_s;
    logic           valid_q_r;
    logic [511:0]   hash_buf_r;
    logic [511:0]   hash_buf_nx_s;
    logic [7:0]     idx_r;
    logic [7:0]     idx_nx_s;
    logic [7:0]     tx_data_r;
    logic [7:0]     tx_data_nx_s;
    logic           tx_valid_r;
    logic           tx_valid_nx_s;
    logic           busy_r;
    logic           busy_nx_s;
    logic           done_r;
    logic           done_nx_s;
    logic           start_s;
    logic           xfer_s;
    logic           last_s;

    // Character at position idx_v of the frame built from digest buf_v.
    function automatic logic [7:0] char_at(input logic [511:0] buf_v, input logic [7:0] idx_v);
        logic [5:0] k_v;
        logic [8:0] lo_v;
        logic [7:0] byte_v;
        logic [3:0] nib_v;
        logic [7:0] chr_v;
        if (HEX_MODE != 32'd0) begin
            k_v = idx_v[6:1];
        end else begin
            k_v = idx_v[5:0];
        end
        lo_v   = 9'd504 - {k_v, 3'b000};
        byte_v = buf_v[lo_v +: 8];
        nib_v  = idx_v[0] ? byte_v[3:0] : byte_v[7:4];
        if ((APPEND_CRLF != 32'd0) && (idx_v >= CR_IDX)) begin
            chr_v = (idx_v == CR_IDX) ? 8'h0D : 8'h0A;
        end else if (HEX_MODE == 32'd0) begin
            chr_v = byte_v;
        end else if (nib_v < 4'd10) begin
            chr_v = 8'h30 + {4'h0, nib_v};
        end else begin
            chr_v = 8'h57 + {4'h0, nib_v};
        end
        return chr_v;
    endfunction

    // valid_q_r resets high so a digest already valid at reset release is not a start.
    assign start_s = hash_valid_i & ~valid_q_r;
    assign xfer_s  = tx_valid_r & tx_ready_i;
    assign last_s  = (idx_r == LAST_IDX);

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nx_s = SEND;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SEND: begin
                if (xfer_s && last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SEND;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Digest buffer and character index next values; buffer only loads on an IDLE start.
    always_comb begin
        hash_buf_nx_s = hash_buf_r;
        idx_nx_s      = idx_r;
        if ((state_r == IDLE) && start_s) begin
            hash_buf_nx_s = hash_i;
            idx_nx_s      = 8'd0;
        end else if (xfer_s) begin
            idx_nx_s = idx_r + 8'd1;
        end else begin
            idx_nx_s = idx_r;
        end
    end

    // Output next values, looked ahead so every output leaves a flop.
    always_comb begin
        tx_valid_nx_s = (state_nx_s == SEND);
        busy_nx_s     = (state_nx_s == SEND);
        done_nx_s     = (state_nx_s == DONE);
        if (state_nx_s == SEND) begin
            tx_data_nx_s = char_at(hash_buf_nx_s, idx_nx_s);
        end else begin
            tx_data_nx_s = 8'h00;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q_r  <= 1'b1;
            hash_buf_r <= 512'd0;
            idx_r      <= 8'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            valid_q_r  <= hash_valid_i;
            hash_buf_r <= hash_buf_nx_s;
            idx_r      <= idx_nx_s;
            tx_data_r  <= tx_data_nx_s;
            tx_valid_r <= tx_valid_nx_s;
            busy_r     <= busy_nx_s;
            done_r     <= done_nx_s;
        end
    end

    assign tx_data_o  = tx_data_r;
    assign tx_valid_o = tx_valid_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;

endmodule

// File: tb/tb_hash_tx.sv
// Scoreboard bench for hash_tx: a hex+CRLF instance and a raw-byte instance,
// expected characters queued by the driver and popped by negedge monitors.
module tb_hash_tx;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [511:0] hash_a, hash_b;
    logic         hv_a, hv_b;
    logic         rdy_a = 1'b1;
    logic         rdy_b;
    logic [7:0]   data_a, data_b;
    logic         val_a, val_b, busy_a, busy_b, done_a, done_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    int cnt_a = 0, cnt_b = 0, dones_a = 0, dones_b = 0;
    bit xfer_prev_a = 1'b0, xfer_cur_a = 1'b0;
    bit stall_a = 1'b0;
    logic [7:0] stall_data_a = 8'h00;
    int ready_mode = 0;
    int cyc = 0;
    string pat = "0123456789abcdef";
    logic [511:0] digest_a = {8{64'h0123456789abcdef}};

    always #5 clk_i = ~clk_i;

    hash_tx u_hex (
        .clk_i(clk_i), .rst_i(rst_i), .hash_i(hash_a), .hash_valid_i(hv_a),
        .tx_data_o(data_a), .tx_valid_o(val_a), .tx_ready_i(rdy_a),
        .busy_o(busy_a), .done_o(done_a)
    );

    hash_tx #(.HEX_MODE(0), .APPEND_CRLF(0)) u_raw (
        .clk_i(clk_i), .rst_i(rst_i), .hash_i(hash_b), .hash_valid_i(hv_b),
        .tx_data_o(data_b), .tx_valid_o(val_b), .tx_ready_i(rdy_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Ready generator: always ready, or ready one cycle in three.
    always @(posedge clk_i) begin
        #1;
        cyc++;
        rdy_a = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    // Monitor for the hex instance.
    always @(negedge clk_i) begin
        xfer_prev_a = xfer_cur_a;
        xfer_cur_a  = val_a && rdy_a;
        check("busy_eq_valid_a", busy_a, val_a);
        if (stall_a && val_a) check("stall_stable_a", data_a, stall_data_a);
        stall_a      = val_a && !rdy_a;
        stall_data_a = data_a;
        if (done_a) dones_a++;
        if (val_a && rdy_a) begin
            cnt_a++;
            checks++;
            if (exp_a.size() == 0) begin
                errors++;
                $display("FAIL extra_char_a: got %0h expected none", data_a);
            end else begin
                logic [7:0] e;
                e = exp_a.pop_front();
                if (data_a !== e) begin
                    errors++;
                    $display("FAIL char_a[%0d]: got %0h expected %0h", cnt_a - 1, data_a, e);
                end
            end
        end
    end

    // Monitor for the raw instance.
    always @(negedge clk_i) begin
        check("busy_eq_valid_b", busy_b, val_b);
        if (done_b) dones_b++;
        if (val_b && rdy_b) begin
            cnt_b++;
            checks++;
            if (exp_b.size() == 0) begin
                errors++;
                $display("FAIL extra_char_b: got %0h expected none", data_b);
            end else begin
                logic [7:0] e;
                e = exp_b.pop_front();
                if (data_b !== e) begin
                    errors++;
                    $display("FAIL char_b[%0d]: got %0h expected %0h", cnt_b - 1, data_b, e);
                end
            end
        end
    end

    task automatic push_frame_a();
        for (int i = 0; i < 128; i++) exp_a.push_back(pat[i % 16]);
        exp_a.push_back(8'h0D);
        exp_a.push_back(8'h0A);
    endtask

    task automatic start_a(input logic [511:0] h);
        hv_a   = 1'b0;
        hash_a = h;
        cnt_a  = 0;
        tick();
        hv_a = 1'b1;
    endtask

    task automatic run_frame_a(input int n, input bit no_bubble);
        int cycles;
        @(negedge clk_i); #1;
        check("valid_before_start_a", val_a, 1'b0);
        @(negedge clk_i); #1;
        check("latency_a", val_a, 1'b1);
        cycles = 1;
        while (!done_a && cycles < 2000) begin
            @(negedge clk_i); #1;
            cycles++;
        end
        check("done_seen_a", done_a, 1'b1);
        check("frame_len_a", cnt_a, n);
        check("done_after_last_xfer_a", xfer_prev_a, 1'b1);
        check("busy_at_done_a", busy_a, 1'b0);
        check("queue_drained_a", exp_a.size(), 0);
        if (no_bubble) check("frame_cycles_a", cycles, n + 1);
        @(negedge clk_i); #1;
        check("done_one_cycle_a", done_a, 1'b0);
    endtask

    task automatic run_frame_b();
        int cycles;
        @(negedge clk_i); #1;
        @(negedge clk_i); #1;
        check("latency_b", val_b, 1'b1);
        check("first_byte_b", data_b, 8'hA5);
        cycles = 1;
        while (!done_b && cycles < 2000) begin
            @(negedge clk_i); #1;
            cycles++;
        end
        check("done_seen_b", done_b, 1'b1);
        check("frame_len_b", cnt_b, 64);
        check("frame_cycles_b", cycles, 65);
        check("queue_drained_b", exp_b.size(), 0);
    endtask

    initial begin
        int snap;
        rst_i  = 1'b0;
        hv_a   = 1'b1;
        hv_b   = 1'b0;
        rdy_b  = 1'b1;
        hash_a = digest_a;
        hash_b = 512'd0;
        #12;
        check("rst_valid_a", val_a, 1'b0);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_done_a", done_a, 1'b0);
        check("rst_data_a", data_a, 8'h00);
        check("rst_valid_b", val_b, 1'b0);
        check("rst_data_b", data_b, 8'h00);
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        repeat (5) tick();
        check("no_start_at_release", val_a, 1'b0);

        // Hex frame, always ready.
        push_frame_a();
        start_a(digest_a);
        run_frame_a(130, 1'b1);

        // Raw frame on the second instance.
        hash_b = 512'd0;
        hash_b[511:504] = 8'hA5;
        hash_b[7:0]     = 8'h3C;
        exp_b.push_back(8'hA5);
        for (int k = 1; k < 63; k++) begin
            hash_b[511 - 8 * k -: 8] = 8'(k);
            exp_b.push_back(8'(k));
        end
        exp_b.push_back(8'h3C);
        tick();
        hv_b = 1'b1;
        run_frame_b();

        // Stalled frame with a start glitch and new digest mid-frame.
        ready_mode = 1;
        push_frame_a();
        start_a(digest_a);
        fork
            run_frame_a(130, 1'b0);
            begin
                for (int i = 0; i < 3000 && cnt_a < 10; i++) @(negedge clk_i);
                #1;
                hv_a = 1'b0;
                tick();
                hash_a = {512{1'b1}};
                hv_a   = 1'b1;
            end
        join
        ready_mode = 0;

        // Valid held high through and after completion; digest changes mid-frame.
        push_frame_a();
        start_a(digest_a);
        snap = dones_a;
        fork
            run_frame_a(130, 1'b1);
            begin
                for (int i = 0; i < 3000 && cnt_a < 20; i++) @(negedge clk_i);
                #1;
                hash_a = {512{1'b1}};
            end
        join
        repeat (200) tick();
        check("no_retrigger_valid", val_a, 1'b0);
        check("no_retrigger_busy", busy_a, 1'b0);
        check("single_done", dones_a, snap + 1);

        // Reset in the middle of a frame.
        push_frame_a();
        start_a(digest_a);
        for (int i = 0; i < 3000 && cnt_a < 40; i++) @(negedge clk_i);
        @(posedge clk_i); #2;
        rst_i = 1'b0;
        #1;
        check("abort_valid", val_a, 1'b0);
        check("abort_busy", busy_a, 1'b0);
        check("abort_data", data_a, 8'h00);
        exp_a.delete();
        snap = dones_a;
        repeat (2) @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        repeat (30) tick();
        check("post_abort_idle", val_a, 1'b0);
        check("post_abort_no_done", dones_a, snap);
        push_frame_a();
        start_a(digest_a);
        run_frame_a(130, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
